// File: rtl/crc_rr_scheduler.sv
// Round-robin scheduler sharing one bit-serial CRC-4 engine among N_REQ
// requesters. A granted 3-bit word takes three division steps. The 4-bit
// remainder is then returned, tagged with the ID of the requester it came from.

// Per-requester priority rank relative to the last granted requester:
// rank 0 is the requester right after r_last, wrapping modulo N_REQ.
module crc_rr_lane #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int K     = 0
) (
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] rank
);
    localparam logic [ID_W:0] KK = K[ID_W:0];
    localparam logic [ID_W:0] NR = N_REQ[ID_W:0];

    logic [ID_W:0] last_x;
    logic [ID_W:0] rank_x;
    logic          unused_rank_msb;

    // Distance from last+1 to this lane, computed without a modulo operator
    always_comb begin
        last_x = {1'b0, last};
        if (KK > last_x) rank_x = KK - last_x - 1'b1;
        else             rank_x = KK + NR - last_x - 1'b1;
    end

    assign rank            = rank_x[ID_W-1:0];
    assign unused_rank_msb = rank_x[ID_W];
endmodule

module crc_rr_scheduler #(
    parameter int          N_REQ = 4,
    parameter int          ID_W  = 2,
    parameter logic [4:0]  GPE   = 5'b10111
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [3*N_REQ-1:0]   i_data,
    output logic [N_REQ-1:0]     o_gnt,
    output logic                 o_busy,
    output logic [3:0]           o_crc,
    output logic [ID_W-1:0]      o_crc_id,
    output logic                 o_crc_valid
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                       state, state_n;
    logic [1:0]                   r_step, step_n;
    logic [7:0]                   sr, sr_n, sr_step;
    logic [ID_W-1:0]              r_last, last_n;
    logic [ID_W-1:0]              r_id, id_n;
    logic [N_REQ-1:0]             gnt_n;
    logic                         busy_n, valid_n;
    logic [3:0]                   crc_n;
    logic [ID_W-1:0]              crc_id_n;

    logic [N_REQ-1:0][2:0]        data_w;
    logic [N_REQ-1:0][ID_W-1:0]   rank;
    logic [ID_W-1:0]              sel_id, best;
    logic                         sel_found;
    logic                         unused_sr_msb;

    // Per-requester data slicing and rank computation
    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign data_w[k] = i_data[3*k+2:3*k];
        crc_rr_lane #(.N_REQ(N_REQ), .ID_W(ID_W), .K(k)) u_lane (
            .last (r_last),
            .rank (rank[k])
        );
    end

    // Pick the requesting lane with the lowest rank (closest after r_last)
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        best      = '1;
        for (int k = 0; k < N_REQ; k++) begin
            if (i_req[k] && (!sel_found || rank[k] < best)) begin
                sel_found = 1'b1;
                best      = rank[k];
                sel_id    = ID_W'(k);
            end
        end
    end

    // One long-division step: subtract GPE when the leading bit is set.
    // sr[7] always clears after the XOR because the MSB of GPE is 1.
    always_comb begin
        if (sr[6]) sr_step = {sr[6:2] ^ GPE, sr[1:0], 1'b0};
        else       sr_step = {sr[6:0], 1'b0};
    end
    assign unused_sr_msb = sr[7];

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        step_n   = r_step;
        sr_n     = sr;
        last_n   = r_last;
        id_n     = r_id;
        gnt_n    = '0;
        busy_n   = o_busy;
        valid_n  = 1'b0;
        crc_n    = o_crc;
        crc_id_n = o_crc_id;
        case (state)
            IDLE: begin
                if (i_en && sel_found) begin
                    sr_n    = {1'b0, data_w[sel_id], 4'b0000};
                    gnt_n   = {{(N_REQ-1){1'b0}}, 1'b1} << sel_id;
                    last_n  = sel_id;
                    id_n    = sel_id;
                    busy_n  = 1'b1;
                    step_n  = 2'd0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sr_n   = sr_step;
                step_n = r_step + 2'd1;
                if (r_step == 2'd2) begin
                    crc_n    = sr_step[6:3];
                    crc_id_n = r_id;
                    valid_n  = 1'b1;
                    busy_n   = 1'b0;
                    step_n   = 2'd0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight word
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            r_step      <= '0;
            sr          <= '0;
            r_last      <= ID_W'(N_REQ-1);
            r_id        <= '0;
            o_gnt       <= '0;
            o_busy      <= 1'b0;
            o_crc       <= '0;
            o_crc_id    <= '0;
            o_crc_valid <= 1'b0;
        end else begin
            state       <= state_n;
            r_step      <= step_n;
            sr          <= sr_n;
            r_last      <= last_n;
            r_id        <= id_n;
            o_gnt       <= gnt_n;
            o_busy      <= busy_n;
            o_crc       <= crc_n;
            o_crc_id    <= crc_id_n;
            o_crc_valid <= valid_n;
        end
    end
endmodule

// File: tb/tb_crc_rr_scheduler.sv
// Directed bench for crc_rr_scheduler: a vector table for single words,
// plus hand-written sequences for enable, fairness and reset mid-shift.
module tb_crc_rr_scheduler;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               i_clk = 1'b0;
    logic               i_reset_n;
    logic               i_en;
    logic [N_REQ-1:0]   i_req;
    logic [3*N_REQ-1:0] i_data;
    logic [N_REQ-1:0]   o_gnt;
    logic               o_busy;
    logic [3:0]         o_crc;
    logic [ID_W-1:0]    o_crc_id;
    logic               o_crc_valid;

    crc_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .GPE(5'b10111)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_en        (i_en),
        .i_req       (i_req),
        .i_data      (i_data),
        .o_gnt       (o_gnt),
        .o_busy      (o_busy),
        .o_crc       (o_crc),
        .o_crc_id    (o_crc_id),
        .o_crc_valid (o_crc_valid)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] data;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic [3:0]  crc;
    } vec_t;

    vec_t       vecs [11];
    logic [3:0] crc_ref [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    // Present one request, check the grant, then check the result 3 cycles on
    task automatic run_word(input vec_t v);
        @(negedge i_clk);
        i_req  = v.req;
        i_data = v.data;
        @(posedge i_clk); #1;
        chk("gnt", o_gnt, v.gnt);
        chk("busy_set", o_busy, 1);
        @(negedge i_clk);
        i_req = '0;
        repeat (2) begin
            @(posedge i_clk); #1;
            chk("valid_early", o_crc_valid, 0);
            chk("gnt_pulse", o_gnt, 0);
        end
        @(posedge i_clk); #1;
        chk("valid", o_crc_valid, 1);
        chk("crc", o_crc, v.crc);
        chk("crc_id", o_crc_id, v.id);
        chk("busy_clr", o_busy, 0);
        @(posedge i_clk); #1;
        chk("valid_pulse", o_crc_valid, 0);
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge i_clk); #1;
            if (o_gnt != '0) ok = 1'b1;
        end
    endtask

    initial begin
        bit         ok;
        int         last_cyc;
        logic [1:0] fair_id  [5];
        logic [3:0] fair_crc [5];

        crc_ref = '{4'b0000, 4'b0111, 4'b1110, 4'b1001,
                    4'b1011, 4'b1100, 4'b0101, 4'b0010};
        // Single request, then both pointer-wrap cases, then all data on req 2
        vecs[0] = '{4'b0001, 12'b000_000_000_101, 4'b0001, 2'd0, 4'b1100};
        vecs[1] = '{4'b1001, 12'b110_000_000_011, 4'b1000, 2'd3, 4'b0101};
        vecs[2] = '{4'b1001, 12'b110_000_000_011, 4'b0001, 2'd0, 4'b1001};
        for (int d = 0; d < 8; d++)
            vecs[3+d] = '{4'b0100, {3'b000, 3'(d), 6'b000000}, 4'b0100, 2'd2, crc_ref[d]};

        fair_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        fair_crc = '{4'b0111, 4'b1110, 4'b1001, 4'b1011, 4'b0111};

        i_reset_n = 1'b0;
        i_en      = 1'b1;
        i_req     = '0;
        i_data    = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_gnt", o_gnt, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_crc", o_crc, 0);
        chk("rst_id", o_crc_id, 0);
        chk("rst_valid", o_crc_valid, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        for (int i = 0; i < 11; i++) run_word(vecs[i]);

        // Enable low blocks grants; r_last is 2 so requester 3 wins next
        @(negedge i_clk);
        i_en   = 1'b0;
        i_req  = 4'b1111;
        i_data = {3'd7, 3'd1, 3'd2, 3'd3};
        repeat (10) begin
            @(posedge i_clk); #1;
            chk("en_low_gnt", o_gnt, 0);
        end
        @(negedge i_clk);
        i_en = 1'b1;
        @(posedge i_clk); #1;
        chk("en_gnt", o_gnt, 4'b1000);
        @(negedge i_clk);
        i_en = 1'b0;
        repeat (2) @(posedge i_clk);
        @(posedge i_clk); #1;
        chk("en_drop_valid", o_crc_valid, 1);
        chk("en_drop_id", o_crc_id, 3);
        chk("en_drop_crc", o_crc, 4'b0010);
        @(posedge i_clk); #1;
        chk("en_drop_no_gnt", o_gnt, 0);
        chk("en_drop_idle", o_busy, 0);
        @(negedge i_clk);
        i_req = '0;
        i_en  = 1'b1;

        // Fairness: all requesting, grants rotate every 4 cycles
        do_reset();
        i_req  = 4'b1111;
        i_data = {3'd4, 3'd3, 3'd2, 3'd1};
        last_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(ok);
            chk("fair_gnt_seen", ok, 1);
            chk("fair_gnt", o_gnt, 4'b0001 << fair_id[i]);
            if (i > 0) chk("fair_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            repeat (3) @(posedge i_clk);
            #1;
            chk("fair_valid", o_crc_valid, 1);
            chk("fair_id", o_crc_id, fair_id[i]);
            chk("fair_crc", o_crc, fair_crc[i]);
            chk("fair_no_gnt", o_gnt, 0);
        end
        @(negedge i_clk);
        i_req = '0;

        // Reset one cycle after the grant discards the in-flight word
        @(negedge i_clk);
        i_req  = 4'b0010;
        i_data = 12'b000_000_010_001;
        @(posedge i_clk); #1;
        chk("mid_gnt", o_gnt, 4'b0010);
        @(negedge i_clk);
        i_req = '0;
        @(posedge i_clk); #1;
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_crc", o_crc, 0);
        chk("mid_rst_id", o_crc_id, 0);
        chk("mid_rst_valid", o_crc_valid, 0);
        chk("mid_rst_gnt", o_gnt, 0);
        repeat (4) begin
            @(posedge i_clk); #1;
            chk("mid_rst_no_valid", o_crc_valid, 0);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_req     = 4'b0011;
        @(posedge i_clk); #1;
        chk("post_rst_gnt", o_gnt, 4'b0001);
        @(negedge i_clk);
        i_req = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("post_rst_valid", o_crc_valid, 1);
        chk("post_rst_crc", o_crc, 4'b0111);
        chk("post_rst_id", o_crc_id, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/crc_rr_scheduler.md
# crc_rr_scheduler

Round-robin scheduler that shares one bit-serial CRC-4 engine (generator 5'b10111, x^4+x^2+x+1) among several requesters. Each requester presents a 3-bit data word. The scheduler grants one requester at a time and runs the 3-step polynomial division on that word. It then returns the 4-bit remainder tagged with the requester ID. The block sits between the per-channel data producers and the CRC consumer logic in the coding chapter designs.

## Interface
- N_REQ, 4, number of requesters (2..4)
- ID_W, 2, width of requester ID; N_REQ <= 2^ID_W
- GPE, 5'b10111, generator polynomial, MSB always 1
- i_clk  in  1  clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_en  in  1  scheduler enable; low blocks new grants, in-flight word completes
- i_req  in  N_REQ  per-requester request level
- i_data  in  3*N_REQ  packed data; requester k uses bits [3k+2:3k]
- o_gnt  out  N_REQ  one-hot grant pulse, one cycle, marks capture of that requester's data
- o_busy  out  1  high while a word is in the engine
- o_crc  out  4  CRC remainder of last completed word
- o_crc_id  out  ID_W  requester ID belonging to o_crc
- o_crc_valid  out  1  one-cycle pulse, o_crc/o_crc_id valid

## Operation
- States: IDLE, SHIFT. A step counter r_step (2 bits, 0..2) is active in SHIFT.
- **Reset values:**
  - outputs: o_gnt=0, o_busy=0, o_crc=0, o_crc_id=0, o_crc_valid=0
  - internal: state=IDLE, r_step=0, shift register=0
  - round-robin pointer r_last=N_REQ-1, so requester 0 has first priority.
- **IDLE:** at a rising edge where i_en=1 and i_req!=0:
  - select the first asserted requester searching r_last+1, r_last+2, … with wrap modulo N_REQ
  - load the 8-bit shift register with {1'b0, data[2:0], 4'b0000}
  - set o_gnt one-hot for the selected requester
  - r_last <= selected ID; latch the ID
  - o_busy <= 1; state <= SHIFT; r_step <= 0.
- **SHIFT, each edge:** one division step.
  - If sr[6]=1: sr[7:3] <= sr[6:2] ^ GPE and sr[2:0] <= {sr[1:0],0}.
  - Else: sr <= {sr[6:0],0}.
  - o_gnt <= 0.
  - r_step increments.
- **Completion:** on the edge with r_step=2 (third step):
  - o_crc <= resulting sr[6:3] (the remainder is formed combinationally from the step's next value)
  - o_crc_id <= latched ID; o_crc_valid <= 1
  - o_busy <= 0; state <= IDLE.
- **Arithmetic:** o_crc = (data · x^4) mod GPE. Reference values:
  - 000→0000, 001→0111, 010→1110, 011→1001
  - 100→1011, 101→1100, 110→0101, 111→0010.
- **Requests in flight:** i_req and i_data are ignored while in SHIFT. A requester must hold i_req and i_data stable until its o_gnt is seen. It may drop i_req in the cycle o_gnt is high. If it holds i_req, that is a new request.
- **i_en low:** in IDLE, no grant is issued. In SHIFT, the current word finishes normally.
- **Reset mid-operation:** the in-flight word is discarded and no o_crc_valid is issued. r_last returns to N_REQ-1.

## Timing
- Capture edge E0. o_gnt is high in cycle E0→E1.
- Division steps occur on E1, E2, E3.
- o_crc_valid is high in cycle E3→E4. Latency is capture-to-valid = 3 cycles.
- Earliest next capture is E4. Maximum throughput is 1 word per 4 cycles.
- o_crc/o_crc_id hold their value until the next completion. o_crc_valid and o_gnt are never high more than one cycle.
- Simultaneous requests: exactly one grant per capture. With all N_REQ requesting continuously, grants rotate 0,1,2,3,0,…
- o_gnt and o_crc_valid never coincide for the same word. o_crc_valid (word n) and o_gnt (word n+1) are never high in the same cycle.

## Test plan
- **Single request:** reset, then i_req=4'b0001 with data0=3'b101.
  - o_gnt=0001 for one cycle.
  - 3 cycles later: o_crc=4'b1100, o_crc_id=0, o_crc_valid pulse.
- **Exhaustive data:** all 8 data values on requester 2. Each result matches the reference value list; o_crc_id=2 each time.
- **Fairness:** i_req=4'b1111 held, data k = k+1.
  - Grant order is 0,1,2,3,0.
  - CRCs in order: 0111, 1110, 1001, 1011, 0111.
  - Grants are 4 cycles apart.
- **Pointer wrap:**
  - After requester 3 is granted, i_req=4'b1001 gives grant to 0 next.
  - After requester 0 is granted, i_req=4'b1001 gives grant to 3 next.
- **Enable:** i_en=0 with i_req=1111 gives no o_gnt for 10 cycles. Dropping i_en during SHIFT still yields the valid pulse for the in-flight word.
- **Reset mid-shift:** assert i_reset_n=0 one cycle after o_gnt.
  - All outputs go to 0 immediately and no valid pulse occurs.
  - After release, requester 0 wins against i_req=4'b0011.
